// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and PC-source selects.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpAddi  = 4'h8;
  localparam logic [3:0] OpLoad  = 4'h9;
  localparam logic [3:0] OpStore = 4'hA;
  localparam logic [3:0] OpBeq   = 4'hB;
  localparam logic [3:0] OpJmp   = 4'hC;
  localparam logic [3:0] OpHalt  = 4'hF;

  localparam logic [1:0] PcSelInc = 2'd0;  // PC + 1
  localparam logic [1:0] PcSelRel = 2'd1;  // PC + sext(imm12)
  localparam logic [1:0] PcSelAbs = 2'd2;  // sext(imm12)

  localparam logic [2:0] AluAdd = 3'd0;

  // 0x1..0x7 carry the ALU operation in their low three bits.
  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h7);
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    return (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive wait cycles; expired flags the WAIT_MAX-th cycle that is still waiting.
module ctrl_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(WAIT_MAX - 1);

  logic [CntW-1:0] count_q, count_d;

  // count_q holds the number of wait cycles already spent before the current one.
  assign expired = run && (count_q == Limit);

  // Next count: clear wins, otherwise advance while waiting.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: fetch/decode/exec/mem/wb sequencing with wait timeout.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic        mem_ready,
  input  logic        zero_flag,
  output logic        ir_load,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        imm_ext_en,
  output logic [2:0]  alu_op,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_wr,
  output logic        wb_sel_mem,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic        bus_error,
  output logic [15:0] retired
);

  state_e      state_q, state_d;
  logic [3:0]  ir_op_q;  // only the opcode field of IR matters to control
  logic        illegal_q, bus_error_q;
  logic [15:0] retired_q;
  logic        fetch_hs, wait_run, wait_clear, wait_expired, retire;

  // Immediate bits are consumed by the datapath, not here.
  logic unused_imm;
  assign unused_imm = ^instr[11:0];

  assign fetch_hs   = (state_q == StFetch) && instr_valid;
  assign wait_run   = ((state_q == StFetch) && !instr_valid) ||
                      ((state_q == StMem) && !mem_ready);
  assign wait_clear = (state_d != state_q);
  assign retire     = (state_d == StFetch) && (state_q inside {StDecode, StExec, StMem, StWb});

  ctrl_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (wait_run),
    .clear  (wait_clear),
    .expired(wait_expired)
  );

  // Next-state decode; a handshake always beats a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (instr_valid)       state_d = StDecode;
        else if (wait_expired) state_d = StHalt;
      end
      StDecode: begin
        if (ir_op_q == OpNop)                               state_d = StFetch;
        else if (ir_op_q == OpHalt || is_reserved(ir_op_q)) state_d = StHalt;
        else                                                state_d = StExec;
      end
      StExec: begin
        if (is_rtype(ir_op_q) || ir_op_q == OpAddi)        state_d = StWb;
        else if (ir_op_q == OpLoad || ir_op_q == OpStore)  state_d = StMem;
        else                                               state_d = StFetch;
      end
      StMem: begin
        if (mem_ready)         state_d = (ir_op_q == OpLoad) ? StWb : StFetch;
        else if (wait_expired) state_d = StHalt;
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Output decode; everything is forced quiet while reset is held.
  always_comb begin
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = PcSelInc;
    imm_ext_en = 1'b0;
    alu_op     = AluAdd;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    wb_sel_mem = 1'b0;
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          mem_rd = 1'b1;
          if (instr_valid) begin
            ir_load = 1'b1;
            pc_en   = 1'b1;
            pc_sel  = PcSelInc;
          end
        end
        StExec: begin
          if (is_rtype(ir_op_q)) begin
            alu_op = ir_op_q[2:0];
          end else if (ir_op_q inside {OpAddi, OpLoad, OpStore}) begin
            alu_op     = AluAdd;
            imm_ext_en = 1'b1;
          end else if (ir_op_q == OpBeq) begin
            if (zero_flag) begin
              pc_en  = 1'b1;
              pc_sel = PcSelRel;
            end
          end else if (ir_op_q == OpJmp) begin
            pc_en  = 1'b1;
            pc_sel = PcSelAbs;
          end
        end
        StMem: begin
          mem_rd = (ir_op_q == OpLoad);
          mem_wr = (ir_op_q == OpStore);
        end
        StWb: begin
          reg_wr     = 1'b1;
          wb_sel_mem = (ir_op_q == OpLoad);
        end
        default: ;
      endcase
    end
  end

  assign state     = state_q;
  assign halted    = (state_q == StHalt);
  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
  assign retired   = retired_q;

  // State, IR opcode, sticky flags and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      ir_op_q     <= 4'h0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      retired_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (fetch_hs) ir_op_q <= instr[15:12];
      if ((state_q == StDecode) && is_reserved(ir_op_q)) illegal_q <= 1'b1;
      if (wait_expired) bus_error_q <= 1'b1;
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

endmodule
